// File: rtl/sub_compare_pkg.sv
// sub_compare_pkg: state encoding and sizing helpers for the chunked subtract-and-compare unit
package sub_compare_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;
  function automatic int chunk_count(input int w, input int c);
    return (c > 0) ? w / c : 1;
  endfunction
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/borrow_chunk_sub.sv
// borrow_chunk_sub: combinational C-bit subtract with borrow in/out and zero detect
module borrow_chunk_sub #(
  parameter int C = 8
) (
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  input  logic         bin,
  output logic [C-1:0] d,
  output logic         bout,
  output logic         zero
);
  assign {bout, d} = {1'b0, a} - {1'b0, b} - {{C{1'b0}}, bin};
  assign zero = (d == '0);
endmodule

// File: rtl/sub_compare_unit.sv
// sub_compare_unit: multi-cycle input1 - input2 with equal/less flags, one chunk per cycle.
// Define SUB_COMPARE_SIGNED_EN to make lessFlag a two's-complement comparison.
module sub_compare_unit
  import sub_compare_pkg::*;
#(
  parameter int GOLOBAL_DATA_BUS_WIDTH = 32,
  parameter int CHUNK_WIDTH            = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              inValid,
  output logic                              inReady,
  input  logic [GOLOBAL_DATA_BUS_WIDTH-1:0] input1,
  input  logic [GOLOBAL_DATA_BUS_WIDTH-1:0] input2,
  output logic                              outValid,
  input  logic                              outReady,
  output logic [GOLOBAL_DATA_BUS_WIDTH-1:0] output1,
  output logic                              equalFlag,
  output logic                              lessFlag
);
  localparam int W  = GOLOBAL_DATA_BUS_WIDTH;
  localparam int C  = CHUNK_WIDTH;
  localparam int N  = chunk_count(W, C);
  localparam int IW = idx_width(N);

  if ((C < 1) || (C > W) || ((W % C) != 0)) begin : g_bad_cfg
    $error("sub_compare_unit: CHUNK_WIDTH must divide GOLOBAL_DATA_BUS_WIDTH");
  end

  sub_state_t    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          borrow_q, borrow_d, zero_q, zero_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, out_q, out_d;
  logic          eq_q, eq_d, lt_q, lt_d, ov_q, ov_d;
  logic [C-1:0]  a_c, b_c, d_c;
  logic          bout, z_c, last, lt_fin;

  // A single subtractor is time-shared across chunks via the index mux
  assign a_c  = a_q[int'(idx_q)*C +: C];
  assign b_c  = b_q[int'(idx_q)*C +: C];
  assign last = (idx_q == IW'(N - 1));

  borrow_chunk_sub #(.C(C)) u_chunk (
    .a(a_c), .b(b_c), .bin(borrow_q), .d(d_c), .bout(bout), .zero(z_c)
  );

`ifdef SUB_COMPARE_SIGNED_EN
  assign lt_fin = d_c[C-1] ^ ((a_q[W-1] != b_q[W-1]) && (d_c[C-1] != a_q[W-1]));
`else
  assign lt_fin = bout;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    ov_d     = ov_q;
    if (state_q == IDLE && inValid) begin
      state_d  = RUN;
      a_d      = input1;
      b_d      = input2;
      idx_d    = '0;
      borrow_d = 1'b0;
      zero_d   = 1'b1;
    end else if (state_q == RUN) begin
      out_d[int'(idx_q)*C +: C] = d_c;
      borrow_d = bout;
      zero_d   = zero_q & z_c;
      idx_d    = last ? '0 : idx_q + IW'(1);
      state_d  = last ? DONE : RUN;
      ov_d     = last;
      eq_d     = last ? (zero_q & z_c) : eq_q;
      lt_d     = last ? lt_fin : lt_q;
    end else if (state_q == DONE && outReady) begin
      state_d = IDLE;
      ov_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      ov_q     <= ov_d;
    end
  end

  assign inReady   = (state_q == IDLE);
  assign outValid  = ov_q;
  assign output1   = out_q;
  assign equalFlag = eq_q;
  assign lessFlag  = lt_q;
endmodule

// File: tb/tb_sub_compare_unit.sv
// tb_sub_compare_unit: randomized and directed checks of sub_compare_unit against an arithmetic model
module tb_sub_compare_unit;
  localparam int W = 32;
  localparam int N = 4;

  logic         clk = 0, rst = 1, inValid = 0, outReady = 0;
  logic [W-1:0] input1 = '0, input2 = '0;
  logic         inReady, outValid, equalFlag, lessFlag;
  logic [W-1:0] output1;
  int           errors = 0, checks = 0;

  sub_compare_unit #(.GOLOBAL_DATA_BUS_WIDTH(W), .CHUNK_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
    .input1(input1), .input2(input2), .outValid(outValid), .outReady(outReady),
    .output1(output1), .equalFlag(equalFlag), .lessFlag(lessFlag)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] m_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    return a - b;
  endfunction
  function automatic logic m_lt(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SUB_COMPARE_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  // Accept one operand pair, scramble the inputs afterwards, and count cycles until outValid
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge clk);
    inValid = 1; input1 = a; input2 = b;
    @(posedge clk); #1;
    inValid = 0; input1 = $urandom; input2 = $urandom;
    lat = 0;
    while (!outValid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op();
    outReady = 1;
    @(posedge clk); #1;
    outReady = 0;
  endtask

  task automatic check_result(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
    checks++;
    if (lat !== N) begin errors++; $display("FAIL %s latency got %0d want %0d", name, lat, N); end
    checks++;
    if (output1 !== m_diff(a, b)) begin errors++; $display("FAIL %s diff got %h want %h", name, output1, m_diff(a, b)); end
    checks++;
    if (equalFlag !== (a == b)) begin errors++; $display("FAIL %s eq got %b want %b", name, equalFlag, a == b); end
    checks++;
    if (lessFlag !== m_lt(a, b)) begin errors++; $display("FAIL %s lt got %b want %b", name, lessFlag, m_lt(a, b)); end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({outValid, output1, equalFlag, lessFlag, inReady} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset outValid=%b output1=%h eq=%b lt=%b inReady=%b", outValid, output1, equalFlag, lessFlag, inReady);
    end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    checks++;
    if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inready got %b want 1", inReady); end
  endtask

  task automatic test_directed();
    logic [W-1:0] av [5] = '{32'd10, 32'h12345678, 32'd3, 32'h100, 32'h80000000};
    logic [W-1:0] bv [5] = '{32'd3, 32'h12345678, 32'd10, 32'd1, 32'd1};
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(av[i], bv[i], lat);
      check_result($sformatf("directed%0d", i), av[i], bv[i], lat);
      finish_op();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    int lat;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : ((i % 2) ? $urandom : (a ^ (32'h1 << $urandom_range(0, 31))));
      do_op(a, b, lat);
      check_result($sformatf("random%0d", i), a, b, lat);
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    int lat;
    do_op(32'hDEADBEEF, 32'h0000BEEF, lat);
    check_result("bp_op", 32'hDEADBEEF, 32'h0000BEEF, lat);
    held = output1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      inValid = (i % 2 == 0); input1 = $urandom; input2 = $urandom;
      @(posedge clk); #1;
      checks++;
      if ({outValid, inReady, output1} !== {1'b1, 1'b0, held}) begin
        errors++; $display("FAIL bp_hold%0d outValid=%b inReady=%b output1=%h want 1 0 %h", i, outValid, inReady, output1, held);
      end
    end
    inValid = 0;
    finish_op();
    checks++;
    if ({outValid, inReady} !== 2'b01) begin errors++; $display("FAIL bp_release outValid=%b inReady=%b want 0 1", outValid, inReady); end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ({outValid, inReady, output1} !== {1'b0, 1'b1, held}) begin
      errors++; $display("FAIL bp_noaccept outValid=%b inReady=%b output1=%h want 0 1 %h", outValid, inReady, output1, held);
    end
  endtask

  task automatic test_reset_midrun();
    int lat;
    @(negedge clk);
    inValid = 1; input1 = 32'h55AA1234; input2 = 32'h11111111;
    @(posedge clk); #1;
    inValid = 0;
    @(posedge clk); #2;
    rst = 1;
    #1;
    checks++;
    if ({outValid, output1, inReady} !== {1'b0, 32'h0, 1'b1}) begin
      errors++; $display("FAIL midrun_reset outValid=%b output1=%h inReady=%b", outValid, output1, inReady);
    end
    @(negedge clk); rst = 0;
    repeat (N + 1) @(posedge clk);
    #1;
    checks++;
    if ({outValid, inReady} !== 2'b01) begin errors++; $display("FAIL midrun_abort outValid=%b inReady=%b want 0 1", outValid, inReady); end
    do_op(32'd5, 32'd5, lat);
    check_result("after_reset", 32'd5, 32'd5, lat);
    finish_op();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    int lat;
    time t0, t1;
    a = $urandom; b = $urandom;
    do_op(a, b, lat);
    t0 = $time;
    check_result("b2b0", a, b, lat);
    finish_op();
    a = $urandom; b = a;
    do_op(a, b, lat);
    t1 = $time;
    check_result("b2b1", a, b, lat);
    checks++;
    if ((t1 - t0) !== 60) begin errors++; $display("FAIL b2b_period got %0t want 60", t1 - t0); end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sub_compare_unit.md
Name: sub_compare_unit

Overview:
- Multi-cycle subtract-and-compare unit, the inverse of the datapath adder.
- Computes `output1 = input1 - input2` one CHUNK_WIDTH slice per cycle, rippling the borrow between slices.
- Produces `equalFlag` (operands equal) and `lessFlag` (`input1 < input2`).
- Sits in front of the accumulate path for index comparison; uses a valid/ready handshake on both sides.

Parameters:
- GOLOBAL_DATA_BUS_WIDTH, 32, operand and result width (W).
- CHUNK_WIDTH, 8, bits subtracted per cycle (C); the chunk count is N = W/C.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- inValid  input  1  operand pair valid.
- inReady  output  1  unit can accept operands.
- input1  input  W  minuend.
- input2  input  W  subtrahend.
- outValid  output  1  result and flags valid.
- outReady  input  1  consumer accepts result.
- output1  output  W  difference, modulo 2^W.
- equalFlag  output  1  1 iff `output1 == 0`.
- lessFlag  output  1  1 iff `input1 < input2` (unsigned by default).

Behaviour:
- Elaboration check: W % C == 0 and 1 <= C <= W; otherwise `$error`.
- Reset (async, any state): state = IDLE; `output1` = 0; `equalFlag` = 0; `lessFlag` = 0; `outValid` = 0. Chunk index, borrow and operand registers are cleared.
- `inReady` = (state == IDLE), combinational; it is 1 immediately after reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - On `inValid && inReady`: latch `input1`/`input2`, index = 0, borrow = 0, zeroAcc = 1, go to RUN.
  - Otherwise hold.
- RUN, chunk i per cycle:
  - {b_out, d_i} = a[i] - b[i] - borrow.
  - Write d_i into `output1` slice i; borrow <= b_out; zeroAcc <= zeroAcc & (d_i == 0).
  - At i == N-1, go to DONE and register the final results:
    - `outValid` = 1.
    - `equalFlag` = zeroAcc & (d_{N-1} == 0).
    - `lessFlag` = final b_out.
- Latency: `outValid` rises exactly N cycles after the accepting edge (4 cycles for W=32, C=8).
- DONE:
  - `output1` and flags are held stable while `outValid` = 1.
  - On `outValid && outReady`, go to IDLE and `outValid` <= 0.
  - No acceptance in the same cycle, because `inReady` is low in DONE.
- Throughput: one operation per N+2 cycles when there is no backpressure.
- `inValid` while busy is ignored; operand changes after acceptance do not affect the result.
- During RUN, `output1` contains partially written slices; consumers use it only when `outValid` = 1.
- `output1` is not cleared on return to IDLE; it holds its last value.
- N == 1 (C == W): RUN lasts one cycle.
- Reset mid-RUN or in DONE aborts the operation; there is no partial output.

Optional Feature:
- Macro SUB_COMPARE_SIGNED_EN.
- Defined: `lessFlag` is the two's-complement comparison, computed on the final cycle as N xor V.
  - N = `output1` MSB.
  - V = (a_msb != b_msb) && (diff_msb != a_msb), using the latched operand MSBs.
- Undefined: `lessFlag` = final borrow (unsigned).
- `output1` and `equalFlag` are identical in both builds.

Decomposition:
- Package sub_compare_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t.
  - A function computing the chunk count and the index width, $clog2(N) with a minimum of 1.
- Natural sub-module: borrow_chunk_sub, a combinational C-bit subtract with borrow-in/borrow-out and a zero-detect output. It is instantiated once and reused per cycle under a mux on the chunk index.

Test Plan (W=32, C=8 unless stated):
1. Accept 10, 3 -> exactly 4 cycles later `outValid` = 1, `output1` = 7, `equalFlag` = 0, `lessFlag` = 0.
2. Accept 0x12345678, 0x12345678 -> `output1` = 0, `equalFlag` = 1, `lessFlag` = 0.
3. Accept 3, 10 -> `output1` = 0xFFFFFFF9, `lessFlag` = 1. Then accept 0x00000100, 1 -> `output1` = 0x000000FF (borrow ripples across chunk 0 into chunk 1).
4. Accept 0x80000000, 1 -> `output1` = 0x7FFFFFFF. `lessFlag` = 0 in the default build; `lessFlag` = 1 with SUB_COMPARE_SIGNED_EN.
5. Hold `outReady` = 0 for 5 cycles in DONE while pulsing `inValid` with new operands -> outputs stable, `inReady` = 0, nothing accepted. Raise `outReady` -> one handshake, then `inReady` = 1 the next cycle.
6. Assert `rst` during the 2nd RUN cycle -> immediately `outValid` = 0 and `output1` = 0. After release, `inReady` = 1 and the next operation (5 - 5) completes with `equalFlag` = 1.
